// File: rtl/banked_ram.sv
// Banked single-port word RAM with read-first host access, a sticky
// out-of-range flag and a bulk fill engine that sweeps every word once.
module banked_ram #(
    parameter int DATA_W    = 8,
    parameter int BANK_AW   = 15,
    parameter int NUM_BANKS = 3,
    parameter int ADDR_W    = 17
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              w_enable,
    input  logic              r_enable,
    output logic [DATA_W-1:0] rdata,
    output logic              rvalid,
    input  logic              fill_start,
    input  logic [DATA_W-1:0] fill_value,
    output logic              busy,
    output logic              addr_err,
    input  logic              err_clear
);

    localparam int unsigned      TOTAL_I = NUM_BANKS * (2 ** BANK_AW);
    localparam logic [ADDR_W:0]  TOTAL   = (ADDR_W+1)'(TOTAL_I);
    localparam logic [ADDR_W-1:0] LAST   = ADDR_W'(TOTAL_I - 1);

    typedef enum logic {IDLE, FILL} state_t;

    state_t              state_q;
    logic [ADDR_W-1:0]   fill_cnt_q;
    logic [DATA_W-1:0]   fill_val_q;
    logic                rvalid_q;
    logic                rd_ok_q;
    logic [ADDR_W-1:0]   rd_bank_q;
    logic [DATA_W-1:0]   hold_q;
    logic                addr_err_q;
    logic                addr_err_d;

    logic                in_range;
    logic                host_ok;
    logic                host_re;
    logic                host_we;
    logic                filling;
    logic                mem_we;
    logic                mem_re;
    logic [ADDR_W-1:0]   mem_addr;
    logic [DATA_W-1:0]   mem_wdata;
    logic [ADDR_W-1:0]   mem_bank;
    logic [BANK_AW-1:0]  mem_off;
    logic [DATA_W-1:0]   rd_mux;
    logic [DATA_W-1:0]   bank_rd [NUM_BANKS];

    // fill_start wins over a same-cycle host access; the engine owns the RAM while busy.
    always_comb begin
        in_range  = {1'b0, addr} < TOTAL;
        host_ok   = reset && (state_q == IDLE) && !fill_start;
        host_re   = host_ok && r_enable;
        host_we   = host_ok && w_enable && in_range;
        filling   = reset && (state_q == FILL);
        mem_we    = filling || host_we;
        mem_re    = host_re && in_range;
        mem_addr  = filling ? fill_cnt_q : addr;
        mem_wdata = filling ? fill_val_q : wdata;
        mem_bank  = mem_addr >> BANK_AW;
        mem_off   = mem_addr[BANK_AW-1:0];

        addr_err_d = addr_err_q;
        if (host_ok && (w_enable || r_enable) && !in_range) begin
            addr_err_d = 1'b1;
        end else if (err_clear) begin
            addr_err_d = 1'b0;
        end
    end

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        logic [DATA_W-1:0] mem [2**BANK_AW];
        logic [DATA_W-1:0] rd_q;
        logic              en;

        assign en = (mem_bank == ADDR_W'(b)) && (mem_we || mem_re);

        // Read and write in one block so a colliding read sees the old word.
        always_ff @(posedge clk) begin
            if (en) begin
                if (mem_we) mem[mem_off] <= mem_wdata;
                if (mem_re) rd_q <= mem[mem_off];
            end
        end

        assign bank_rd[b] = rd_q;
    end

    always_comb begin
        rd_mux = '0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            if (rd_bank_q == ADDR_W'(b)) rd_mux = bank_rd[b];
        end
        rdata = rvalid_q ? (rd_ok_q ? rd_mux : '0) : hold_q;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= IDLE;
            fill_cnt_q <= '0;
            fill_val_q <= '0;
            rvalid_q   <= 1'b0;
            rd_ok_q    <= 1'b0;
            rd_bank_q  <= '0;
            hold_q     <= '0;
            addr_err_q <= 1'b0;
        end else begin
            rvalid_q   <= host_re;
            hold_q     <= rdata;
            addr_err_q <= addr_err_d;
            if (host_re) begin
                rd_ok_q   <= in_range;
                rd_bank_q <= mem_bank;
            end
            case (state_q)
                IDLE: begin
                    if (fill_start) begin
                        state_q    <= FILL;
                        fill_cnt_q <= '0;
                        fill_val_q <= fill_value;
                    end
                end
                FILL: begin
                    fill_cnt_q <= fill_cnt_q + 1'b1;
                    if (fill_cnt_q == LAST) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign rvalid   = rvalid_q;
    assign busy     = (state_q == FILL);
    assign addr_err = addr_err_q;

endmodule

// File: tb/tb_banked_ram.sv
// Directed bench for banked_ram on a reduced geometry (3 banks x 16 words)
// so a full fill and full sweeps stay short.
module tb_banked_ram;
    localparam int DW    = 8;
    localparam int BAW   = 4;
    localparam int NB    = 3;
    localparam int AW    = 6;
    localparam int TOTAL = NB * (2 ** BAW);

    logic          clk = 1'b0;
    logic          reset;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          w_enable;
    logic          r_enable;
    logic [DW-1:0] rdata;
    logic          rvalid;
    logic          fill_start;
    logic [DW-1:0] fill_value;
    logic          busy;
    logic          addr_err;
    logic          err_clear;

    logic [DW-1:0] mdl [64];
    int            n_checks = 0;
    int            n_fail   = 0;

    always #5 clk = ~clk;

    banked_ram #(
        .DATA_W(DW), .BANK_AW(BAW), .NUM_BANKS(NB), .ADDR_W(AW)
    ) dut (
        .clk(clk), .reset(reset), .addr(addr), .wdata(wdata),
        .w_enable(w_enable), .r_enable(r_enable), .rdata(rdata),
        .rvalid(rvalid), .fill_start(fill_start), .fill_value(fill_value),
        .busy(busy), .addr_err(addr_err), .err_clear(err_clear)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int a, input logic [DW-1:0] d);
        addr = AW'(a); wdata = d; w_enable = 1'b1;
        step();
        w_enable = 1'b0;
        if (a < TOTAL) mdl[a] = d;
    endtask

    task automatic rd_chk(input int a, input string tag);
        addr = AW'(a); r_enable = 1'b1;
        step();
        r_enable = 1'b0;
        check_eq($sformatf("%s@%0d rvalid", tag, a), 32'(rvalid), 32'd1);
        check_eq($sformatf("%s@%0d rdata", tag, a), 32'(rdata),
                 (a < TOTAL) ? 32'(mdl[a]) : 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        reset = 1'b0; addr = '0; wdata = '0; w_enable = 1'b0; r_enable = 1'b0;
        fill_start = 1'b0; fill_value = '0; err_clear = 1'b0;
        for (int i = 0; i < 64; i++) mdl[i] = '0;
        step(); step();
        check_eq("rst rvalid", 32'(rvalid), 32'd0);
        check_eq("rst rdata", 32'(rdata), 32'd0);
        check_eq("rst busy", 32'(busy), 32'd0);
        check_eq("rst addr_err", 32'(addr_err), 32'd0);
        reset = 1'b1;
        step();

        // Address-as-data sweep across all banks.
        for (int i = 0; i < TOTAL; i++) wr(i, 8'(i));
        for (int i = 0; i < TOTAL; i++) rd_chk(i, "seq");
        step();
        check_eq("idle rvalid", 32'(rvalid), 32'd0);
        check_eq("hold rdata", 32'(rdata), 32'd47);

        // Bank boundaries and their neighbours.
        wr(15, 8'h11); wr(16, 8'h22); wr(31, 8'h33); wr(32, 8'h44);
        for (int i = 14; i <= 17; i++) rd_chk(i, "edge");
        for (int i = 30; i <= 33; i++) rd_chk(i, "edge");

        // Out-of-range write/read, sticky flag, clear, and set-over-clear.
        check_eq("err pre", 32'(addr_err), 32'd0);
        wr(48, 8'hFF);
        check_eq("err oor write", 32'(addr_err), 32'd1);
        rd_chk(48, "oor");
        rd_chk(0, "after oor");
        check_eq("err sticky", 32'(addr_err), 32'd1);
        err_clear = 1'b1; step(); err_clear = 1'b0;
        check_eq("err cleared", 32'(addr_err), 32'd0);
        addr = 6'd63; r_enable = 1'b1; err_clear = 1'b1;
        step();
        r_enable = 1'b0; err_clear = 1'b0;
        check_eq("err set prio", 32'(addr_err), 32'd1);
        check_eq("oor63 rvalid", 32'(rvalid), 32'd1);
        check_eq("oor63 rdata", 32'(rdata), 32'd0);
        err_clear = 1'b1; step(); err_clear = 1'b0;
        check_eq("err cleared2", 32'(addr_err), 32'd0);

        // Read-first on a same-cycle collision.
        wr(20, 8'h64);
        addr = 6'd20; wdata = 8'h5A; w_enable = 1'b1; r_enable = 1'b1;
        step();
        w_enable = 1'b0; r_enable = 1'b0;
        check_eq("rf rvalid", 32'(rvalid), 32'd1);
        check_eq("rf old data", 32'(rdata), 32'h64);
        mdl[20] = 8'h5A;
        rd_chk(20, "rf new");

        // Fill with host strobes that must all be ignored.
        fill_value = 8'hA5; fill_start = 1'b1;
        addr = 6'd50; w_enable = 1'b1; r_enable = 1'b1;
        step();
        fill_value = 8'h00;
        n = 0;
        while (busy === 1'b1 && n < 200) begin
            n++;
            check_eq($sformatf("fill rvalid c%0d", n), 32'(rvalid), 32'd0);
            check_eq($sformatf("fill addr_err c%0d", n), 32'(addr_err), 32'd0);
            addr = (n % 2 == 1) ? 6'd60 : AW'(n % TOTAL);
            wdata = 8'h00; w_enable = 1'b1; r_enable = 1'b1; fill_start = 1'b1;
            step();
        end
        w_enable = 1'b0; r_enable = 1'b0; fill_start = 1'b0;
        check_eq("fill busy cycles", 32'(n), 32'(TOTAL));
        check_eq("fill end rvalid", 32'(rvalid), 32'd0);
        check_eq("fill end addr_err", 32'(addr_err), 32'd0);
        for (int i = 0; i < TOTAL; i++) mdl[i] = 8'hA5;
        for (int i = 0; i < TOTAL; i++) rd_chk(i, "fill");

        // Reset partway through a second fill aborts it.
        rd_chk(60, "arm err");
        fill_value = 8'hC3; fill_start = 1'b1;
        step();
        fill_start = 1'b0;
        check_eq("fill2 busy", 32'(busy), 32'd1);
        repeat (20) step();
        check_eq("fill2 busy c20", 32'(busy), 32'd1);
        check_eq("fill2 err held", 32'(addr_err), 32'd1);
        reset = 1'b0;
        addr = 6'd25; wdata = 8'h99; w_enable = 1'b1; r_enable = 1'b1; err_clear = 1'b0;
        step();
        check_eq("abort busy", 32'(busy), 32'd0);
        check_eq("abort rvalid", 32'(rvalid), 32'd0);
        check_eq("abort rdata", 32'(rdata), 32'd0);
        check_eq("abort addr_err", 32'(addr_err), 32'd0);
        reset = 1'b1; w_enable = 1'b0; r_enable = 1'b0;
        step();
        check_eq("post rst busy", 32'(busy), 32'd0);
        for (int i = 0; i < 20; i++) mdl[i] = 8'hC3;
        for (int i = 0; i < TOTAL; i++) rd_chk(i, "abort");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
